// File: rtl/sample_ascii_tx.sv
// ============================================================================
//  Module      : sample_ascii_tx
//  Description : Converts signed DATA_W-bit samples into newline-delimited
//                ASCII decimal text: optional '-', decimal digits without
//                leading zeros, then TERM_CHAR. One byte per out_ready.
//  Ports       : clk, rst_n          - clock, async active-low reset
//                in_valid/in_ready   - sample handshake, in_data sample
//                out_valid/out_ready - byte handshake, out_data byte,
//                                      out_last with terminator byte
//                sample_count        - lines fully emitted (wraps at 2^32)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sample_ascii_tx #(
    parameter int         DATA_W     = 22,
    parameter int         NUM_DIGITS = 7,
    parameter logic [7:0] TERM_CHAR  = 8'h0A
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_data,
    output logic              out_last,
    output logic [31:0]       sample_count
);

    localparam int PTR_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam int BCD_W = 4 * NUM_DIGITS;

    localparam logic [7:0] c_ASCII_MINUS = 8'h2D;
    localparam logic [7:0] c_ASCII_ZERO  = 8'h30;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CONV   = 3'd1,
        S_SIGN   = 3'd2,
        S_DIGITS = 3'd3,
        S_TERM   = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic               r_in_ready;
    logic               r_neg;
    logic [DATA_W-1:0]  r_mag;
    logic [BCD_W-1:0]   r_bcd;
    logic [BCD_W-1:0]   w_bcd_adj;
    logic [CNT_W-1:0]   r_cnt;
    logic [PTR_W-1:0]   r_ptr;
    logic [PTR_W-1:0]   w_lead;
    logic [3:0]         w_digit;
    logic [31:0]        r_count;
    logic               w_accept;
    logic               w_conv_done;

    assign w_accept     = in_valid && r_in_ready;
    // Counter reaching DATA_W marks the one extra CONV cycle in which the
    // leading digit is located from the registered BCD result, keeping the
    // priority search off the add-3 path.
    assign w_conv_done  = (r_cnt == CNT_W'(DATA_W));
    assign in_ready     = r_in_ready;
    assign sample_count = r_count;

    // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dabble
        assign w_bcd_adj[4*g +: 4] = (r_bcd[4*g +: 4] >= 4'd5) ?
                                     (r_bcd[4*g +: 4] + 4'd3) : r_bcd[4*g +: 4];
    end

    // Most significant non-zero nibble; nibble 0 when the value is zero.
    always_comb begin
        w_lead = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_bcd[4*i +: 4] != 4'd0) begin
                w_lead = PTR_W'(i);
            end
        end
    end

    always_comb begin
        w_digit = 4'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_ptr == PTR_W'(i)) begin
                w_digit = r_bcd[4*i +: 4];
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and byte outputs; outputs decode registered state only.
    always_comb begin
        w_next    = r_state;
        out_valid = 1'b0;
        out_data  = 8'h00;
        out_last  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_next = S_CONV;
            end
            S_CONV: begin
                if (w_conv_done) w_next = r_neg ? S_SIGN : S_DIGITS;
            end
            S_SIGN: begin
                out_valid = 1'b1;
                out_data  = c_ASCII_MINUS;
                if (out_ready) w_next = S_DIGITS;
            end
            S_DIGITS: begin
                out_valid = 1'b1;
                out_data  = c_ASCII_ZERO + {4'd0, w_digit};
                if (out_ready && (r_ptr == '0)) w_next = S_TERM;
            end
            S_TERM: begin
                out_valid = 1'b1;
                out_data  = TERM_CHAR;
                out_last  = 1'b1;
                if (out_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_ready <= 1'b0;
            r_neg      <= 1'b0;
            r_mag      <= '0;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_ptr      <= '0;
            r_count    <= '0;
        end else begin
            // Registered so in_ready first rises one edge after reset release.
            r_in_ready <= (w_next == S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_neg <= in_data[DATA_W-1];
                        // Unsigned DATA_W-bit magnitude: the most negative
                        // value maps to 2^(DATA_W-1) without overflow.
                        r_mag <= in_data[DATA_W-1] ? (~in_data + DATA_W'(1)) : in_data;
                        r_bcd <= '0;
                        r_cnt <= '0;
                    end
                end
                S_CONV: begin
                    if (!w_conv_done) begin
                        r_bcd <= {w_bcd_adj[BCD_W-2:0], r_mag[DATA_W-1]};
                        r_mag <= {r_mag[DATA_W-2:0], 1'b0};
                        r_cnt <= r_cnt + CNT_W'(1);
                    end else begin
                        r_ptr <= w_lead;
                    end
                end
                S_DIGITS: begin
                    if (out_ready && (r_ptr != '0)) r_ptr <= r_ptr - PTR_W'(1);
                end
                S_TERM: begin
                    if (out_ready) r_count <= r_count + 32'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire
